// File: rtl/uart_tx_arb.sv
// Four-requester round-robin arbiter feeding a single UART transmitter.
// A grant may run as a burst of up to BURST_MAX bytes before re-arbitration.
module uart_tx_arb #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [3:0]  done,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_end
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] WAIT_END   = 1'b1;
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  logic [0:0] state_reg, state_next;
  logic [1:0] last_grant_reg, last_grant_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;
  logic [1:0] owner_reg, owner_next;
  logic       busy_reg, busy_next;
  logic       tx_start_reg, tx_start_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [3:0] ack_reg, ack_next;
  logic [3:0] done_reg, done_next;

  logic [7:0] req_byte [4];
  logic [3:0] req_rot;
  logic       win_found;
  logic [1:0] win_idx;

  // req_rot[k] is the request of requester (last_grant + 1 + k) mod 4
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      localparam logic [1:0] OFS = 2'((gi + 1) % 4);
      assign req_byte[gi] = req_data[8*gi +: 8];
      assign req_rot[gi]  = req[last_grant_reg + OFS];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_idx   = last_grant_reg + 2'(k + 1);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    owner_next      = owner_reg;
    busy_next       = busy_reg;
    tx_start_next   = 1'b0;
    tx_data_next    = tx_data_reg;
    ack_next        = 4'b0000;
    done_next       = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (enable && !tx_busy && win_found) begin
          tx_start_next  = 1'b1;
          tx_data_next   = req_byte[win_idx];
          ack_next       = 4'b0001 << win_idx;
          owner_next     = win_idx;
          busy_next      = 1'b1;
          burst_cnt_next = 4'd0;
          state_next     = WAIT_END;
        end
      end
      default: begin
        if (tx_end) begin
          done_next = 4'b0001 << owner_reg;
          // Continuation ignores enable: only new grants are gated
          if (req[owner_reg] && (burst_cnt_reg < BURST_LAST)) begin
            tx_start_next  = 1'b1;
            tx_data_next   = req_byte[owner_reg];
            ack_next       = 4'b0001 << owner_reg;
            burst_cnt_next = burst_cnt_reg + 4'd1;
          end else begin
            last_grant_next = owner_reg;
            busy_next       = 1'b0;
            state_next      = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 2'd3;
      burst_cnt_reg  <= 4'd0;
      owner_reg      <= 2'd0;
      busy_reg       <= 1'b0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= 8'h00;
      ack_reg        <= 4'b0000;
      done_reg       <= 4'b0000;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
      owner_reg      <= owner_next;
      busy_reg       <= busy_next;
      tx_start_reg   <= tx_start_next;
      tx_data_reg    <= tx_data_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
    end
  end

  assign ack      = ack_reg;
  assign done     = done_reg;
  assign owner    = owner_reg;
  assign busy     = busy_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two instances (BURST_MAX=4 and 1), each with a simple
// transmitter model; expected transfers are queued and matched on tx_start.
module tb_uart_tx_arb;

  localparam int TX_LEN = 5;

  typedef struct {
    logic [1:0] who;
    logic [7:0] data;
    int         gap;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b0;
  logic        enable   = 1'b0;
  logic [3:0]  req      = 4'b0000;
  logic [31:0] req_data = 32'h0;

  logic [3:0] ack_a, done_a, ack_b, done_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, tx_start_a, busy_b, tx_start_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_busy_a = 1'b0, tx_end_a = 1'b0;
  logic       tx_busy_b = 1'b0, tx_end_b = 1'b0;
  int         tx_cnt_a = 0, tx_cnt_b = 0;
  int         end_cyc_a = 0, end_cyc_b = 0;

  uart_tx_arb #(.BURST_MAX(4)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
    .ack(ack_a), .done(done_a), .owner(owner_a), .busy(busy_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(tx_busy_a), .tx_end(tx_end_a)
  );

  uart_tx_arb #(.BURST_MAX(1)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
    .ack(ack_b), .done(done_b), .owner(owner_b), .busy(busy_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b), .tx_end(tx_end_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: not reset, so a byte in flight survives a DUT reset
  always @(posedge clk) begin
    tx_end_a <= 1'b0;
    if (tx_start_a) begin
      tx_busy_a <= 1'b1;
      tx_cnt_a  <= TX_LEN;
    end else if (tx_busy_a) begin
      tx_cnt_a <= tx_cnt_a - 1;
      if (tx_cnt_a == 1) begin
        tx_busy_a <= 1'b0;
        tx_end_a  <= 1'b1;
      end
    end
    if (tx_end_a) end_cyc_a <= cyc;
  end

  always @(posedge clk) begin
    tx_end_b <= 1'b0;
    if (tx_start_b) begin
      tx_busy_b <= 1'b1;
      tx_cnt_b  <= TX_LEN;
    end else if (tx_busy_b) begin
      tx_cnt_b <= tx_cnt_b - 1;
      if (tx_cnt_b == 1) begin
        tx_busy_b <= 1'b0;
        tx_end_b  <= 1'b1;
      end
    end
    if (tx_end_b) end_cyc_b <= cyc;
  end

  logic       sel_b = 1'b0;
  logic       m_tx_start, m_busy, m_tx_busy;
  logic [3:0] m_ack, m_done;
  logic [1:0] m_owner;
  logic [7:0] m_tx_data;
  int         m_end_cyc;

  always_comb begin
    m_tx_start = sel_b ? tx_start_b : tx_start_a;
    m_busy     = sel_b ? busy_b     : busy_a;
    m_tx_busy  = sel_b ? tx_busy_b  : tx_busy_a;
    m_ack      = sel_b ? ack_b      : ack_a;
    m_done     = sel_b ? done_b     : done_a;
    m_owner    = sel_b ? owner_b    : owner_a;
    m_tx_data  = sel_b ? tx_data_b  : tx_data_a;
    m_end_cyc  = sel_b ? end_cyc_b  : end_cyc_a;
  end

  int   vec = 0;
  int   err = 0;
  exp_t exp_q[$];
  exp_t cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [7:0] data, input int gap, input logic last);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.gap  = gap;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Checks the current negedge first, then steps up to budget cycles
  task automatic wait_tx(input int budget);
    int n;
    n = 0;
    while (!m_tx_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    cur = exp_q.pop_front();
    chk("tx_start_seen", m_tx_start, 1);
    if (m_tx_start) begin
      $display("tx cyc=%0d owner=%0d data=%02h ack=%b gap=%0d", cyc, m_owner, m_tx_data, m_ack, cyc - m_end_cyc);
      chk("owner", m_owner, cur.who);
      chk("tx_data", m_tx_data, cur.data);
      chk("ack", m_ack, 4'b0001 << cur.who);
      chk("busy_at_start", m_busy, 1);
      chk("tx_busy_at_start", m_tx_busy, 0);
      if (cur.gap != 0) chk("end_to_start_gap", cyc - m_end_cyc, cur.gap);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    chk("ack_one_cycle", m_ack, 0);
    chk("tx_start_one_cycle", m_tx_start, 0);
    while (m_done == 4'b0000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done", m_done, 4'b0001 << cur.who);
    chk("busy_after_done", m_busy, !cur.last);
  endtask

  task automatic idle_reset();
    req    = 4'b0000;
    enable = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start_a, 0);
    chk("rst_tx_data", tx_data_a, 8'h00);
    chk("rst_ack", ack_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_owner", owner_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_b_busy", busy_b, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single byte from requester 0
    enable   = 1'b1;
    req_data = 32'h0000_0041;
    req      = 4'b0001;
    push(2'd0, 8'h41, 0, 1'b1);
    wait_tx(1);
    req = 4'b0000;
    wait_done(20);

    // Burst limit: requester 2 sends 6 bytes with requester 0 competing
    req_data = 32'h00C0_00A0;
    req      = 4'b0101;
    push(2'd2, 8'hC0, 0, 1'b0);
    push(2'd2, 8'hC1, 1, 1'b0);
    push(2'd2, 8'hC2, 1, 1'b0);
    push(2'd2, 8'hC3, 1, 1'b1);
    push(2'd0, 8'hA0, 2, 1'b1);
    push(2'd2, 8'hC4, 2, 1'b0);
    push(2'd2, 8'hC5, 1, 1'b1);
    wait_tx(2); req_data[23:16] = 8'hC1; wait_done(20);
    wait_tx(2); req_data[23:16] = 8'hC2; wait_done(20);
    wait_tx(2); req_data[23:16] = 8'hC3; wait_done(20);
    wait_tx(2); req_data[23:16] = 8'hC4; wait_done(20);
    wait_tx(2); req[0] = 1'b0;            wait_done(20);
    wait_tx(2); req_data[23:16] = 8'hC5; wait_done(20);
    wait_tx(2); req[2] = 1'b0;            wait_done(20);

    // Round robin with BURST_MAX=1
    sel_b = 1'b1;
    idle_reset();
    enable   = 1'b1;
    req_data = 32'h3332_3130;
    req      = 4'b1111;
    push(2'd0, 8'h30, 0, 1'b1);
    push(2'd1, 8'h31, 2, 1'b1);
    push(2'd2, 8'h32, 2, 1'b1);
    push(2'd3, 8'h33, 2, 1'b1);
    push(2'd0, 8'h30, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_tx(2);
      if (i == 4) req = 4'b0000;
      wait_done(20);
    end

    // Enable gating; in-flight byte completes after enable drops
    sel_b = 1'b0;
    idle_reset();
    req_data = 32'h005A_0000;
    req      = 4'b0100;
    repeat (5) begin
      @(negedge clk);
      chk("no_start_disabled", m_tx_start, 0);
    end
    enable = 1'b1;
    push(2'd2, 8'h5A, 0, 1'b1);
    wait_tx(1);
    req    = 4'b0000;
    enable = 1'b0;
    wait_done(20);
    enable = 1'b1;

    // Reset while a byte is on the line
    req_data = 32'h0000_7700;
    req      = 4'b0010;
    push(2'd1, 8'h77, 0, 1'b1);
    wait_tx(2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx_start", m_tx_start, 0);
    chk("midrst_tx_data", m_tx_data, 8'h00);
    chk("midrst_ack", m_ack, 0);
    chk("midrst_done", m_done, 0);
    chk("midrst_owner", m_owner, 0);
    chk("midrst_busy", m_busy, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_no_done", m_done, 0);
      if (m_tx_start) break;
    end
    push(2'd1, 8'h77, 0, 1'b1);
    wait_tx(0);
    req = 4'b0000;
    wait_done(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
